// File: rtl/set_sequencer.sv
// set_sequencer
// Turns the four debounced clock-setting buttons into a mode/position state
// machine. Emits single-cycle increment pulses for the time counters and the
// alarm registers. Drives a per-digit blank mask for the display blink.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   i_sw0        mode button (1 = pressed)
//   i_sw1        position button
//   i_sw2        increment button (auto-repeats while held)
//   i_sw3        alarm-enable toggle button
//   o_mode       0 = CLOCK, 1 = TIME_SET, 2 = ALARM_SET
//   o_position   0 = sec, 1 = min, 2 = hour
//   o_inc_time   one-hot {hour,min,sec} increment pulse to the time counters
//   o_inc_alarm  one-hot {hour,min,sec} increment pulse to the alarm registers
//   o_alarm_en   alarm enable
//   o_blank      one-hot {hour,min,sec} digit-pair blank mask
module set_sequencer #(
  parameter logic [31:0] BLINK_DIV   = 32'd25_000_000,
  parameter logic [31:0] TIMEOUT     = 32'd500_000_000,
  parameter logic [31:0] REPEAT_DLY  = 32'd50_000_000,
  parameter logic [31:0] REPEAT_RATE = 32'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic [2:0] o_inc_time,
  output logic [2:0] o_inc_alarm,
  output logic       o_alarm_en,
  output logic [2:0] o_blank
);

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_TIME_SET  = 2'd1,
    MODE_ALARM_SET = 2'd2
  } mode_t;

  mode_t       mode, mode_n;
  logic [1:0]  position_n;
  logic [3:0]  sw, prev_sw, press;
  logic        alarm_en_n;
  logic [2:0]  inc_time_n, inc_alarm_n, blank_n;
  logic [31:0] idle_cnt, idle_n;
  logic [31:0] hold_cnt, hold_n;
  logic [31:0] blink_cnt, blink_n;
  logic        held, held_n;
  logic        repeating, repeating_n;
  logic        phase, phase_n;
  logic        set_mode, repeat_due, pulse, restart_blink;

  assign sw       = {i_sw3, i_sw2, i_sw1, i_sw0};
  assign press    = sw & ~prev_sw;
  assign set_mode = (mode != MODE_CLOCK);
  assign o_mode   = mode;

  always_comb begin
    // NOTE: every variable gets a default first; a path that leaves one
    // unassigned would infer a latch.
    mode_n        = mode;
    position_n    = o_position;
    alarm_en_n    = o_alarm_en ^ press[3];
    inc_time_n    = 3'b000;
    inc_alarm_n   = 3'b000;
    idle_n        = idle_cnt + 32'd1;
    hold_n        = 32'd0;
    held_n        = 1'b0;
    repeating_n   = 1'b0;
    repeat_due    = 1'b0;
    pulse         = 1'b0;
    restart_blink = 1'b0;
    blink_n       = blink_cnt + 32'd1;
    phase_n       = phase;

    // Repeat schedule runs independently of the press priority chain: a
    // higher-priority action in a due cycle swallows that pulse only.
    if (held && sw[2]) begin
      held_n      = 1'b1;
      repeating_n = repeating;
      if ((!repeating && hold_cnt == REPEAT_DLY - 32'd1) ||
          ( repeating && hold_cnt == REPEAT_RATE - 32'd1)) begin
        repeat_due  = 1'b1;
        repeating_n = 1'b1;
        hold_n      = 32'd0;
      end else begin
        hold_n = hold_cnt + 32'd1;
      end
    end

    if (press[0]) begin
      case (mode)
        MODE_CLOCK:    mode_n = MODE_TIME_SET;
        MODE_TIME_SET: mode_n = MODE_ALARM_SET;
        default:       mode_n = MODE_CLOCK;
      endcase
      position_n    = 2'd0;
      held_n        = 1'b0;
      hold_n        = 32'd0;
      repeating_n   = 1'b0;
      idle_n        = 32'd0;
      restart_blink = 1'b1;
    end else if (set_mode && idle_cnt == TIMEOUT - 32'd1) begin
      mode_n      = MODE_CLOCK;
      position_n  = 2'd0;
      held_n      = 1'b0;
      hold_n      = 32'd0;
      repeating_n = 1'b0;
    end else if (set_mode && press[1]) begin
      position_n    = (o_position == 2'd2) ? 2'd0 : o_position + 2'd1;
      idle_n        = 32'd0;
      restart_blink = 1'b1;
    end else if (set_mode && press[2]) begin
      pulse       = 1'b1;
      held_n      = 1'b1;
      hold_n      = 32'd0;
      repeating_n = 1'b0;
      idle_n      = 32'd0;
    end else if (repeat_due) begin
      pulse  = 1'b1;
      idle_n = 32'd0;
    end

    if (press[3]) idle_n = 32'd0;

    if (pulse) begin
      if (mode == MODE_TIME_SET) inc_time_n  = 3'b001 << o_position;
      else                       inc_alarm_n = 3'b001 << o_position;
    end

    if (restart_blink) begin
      blink_n = 32'd0;
      phase_n = 1'b1;
    end else if (blink_cnt == BLINK_DIV - 32'd1) begin
      blink_n = 32'd0;
      phase_n = ~phase;
    end

    // Clock mode parks every counter so the next set session starts clean.
    if (mode_n == MODE_CLOCK) begin
      idle_n      = 32'd0;
      hold_n      = 32'd0;
      held_n      = 1'b0;
      repeating_n = 1'b0;
      blink_n     = 32'd0;
      phase_n     = 1'b1;
    end

    // The edited digit stays lit while sw2 is held so increments are visible.
    blank_n = (mode_n != MODE_CLOCK && !phase_n && !held_n) ?
              (3'b001 << position_n) : 3'b000;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      mode        <= MODE_CLOCK;
      o_position  <= 2'd0;
      o_inc_time  <= 3'b000;
      o_inc_alarm <= 3'b000;
      o_alarm_en  <= 1'b0;
      o_blank     <= 3'b000;
      prev_sw     <= 4'b1111;
      idle_cnt    <= 32'd0;
      hold_cnt    <= 32'd0;
      blink_cnt   <= 32'd0;
      held        <= 1'b0;
      repeating   <= 1'b0;
      phase       <= 1'b1;
    end else begin
      mode        <= mode_n;
      o_position  <= position_n;
      o_inc_time  <= inc_time_n;
      o_inc_alarm <= inc_alarm_n;
      o_alarm_en  <= alarm_en_n;
      o_blank     <= blank_n;
      prev_sw     <= sw;
      idle_cnt    <= idle_n;
      hold_cnt    <= hold_n;
      blink_cnt   <= blink_n;
      held        <= held_n;
      repeating   <= repeating_n;
      phase       <= phase_n;
    end
  end

endmodule

// File: tb/tb_set_sequencer.sv
// tb_set_sequencer
// Self-checking bench for set_sequencer: a vector table for single-press
// behaviour, hand-written sequences for repeat, timeout, blink and reset,
// then randomized buttons compared against a cycle-time based model.
module tb_set_sequencer;

  localparam logic [31:0] BLINK_DIV   = 32'd4;
  localparam logic [31:0] TIMEOUT     = 32'd50;
  localparam logic [31:0] REPEAT_DLY  = 32'd8;
  localparam logic [31:0] REPEAT_RATE = 32'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [1:0] o_mode, o_position;
  logic [2:0] o_inc_time, o_inc_alarm, o_blank;
  logic       o_alarm_en;

  always #5 clk = ~clk;

  set_sequencer #(
    .BLINK_DIV  (BLINK_DIV),
    .TIMEOUT    (TIMEOUT),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sw0      (sw[0]),
    .i_sw1      (sw[1]),
    .i_sw2      (sw[2]),
    .i_sw3      (sw[3]),
    .o_mode     (o_mode),
    .o_position (o_position),
    .o_inc_time (o_inc_time),
    .o_inc_alarm(o_inc_alarm),
    .o_alarm_en (o_alarm_en),
    .o_blank    (o_blank)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] sw;
    logic [1:0] mode;
    logic [1:0] pos;
    logic [2:0] it;
    logic [2:0] ia;
    logic       en;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic [3:0] s, logic [1:0] m, logic [1:0] p,
                                  logic [2:0] it, logic [2:0] ia, logic en);
    vec_t v;
    v.sw = s; v.mode = m; v.pos = p; v.it = it; v.ia = ia; v.en = en;
    vecs.push_back(v);
  endfunction

  // Model state for the randomized phase.
  int         m_mode, m_pos, last_act, press_t, blink_t;
  bit         m_en, m_held;
  logic [3:0] m_prev;

  initial begin
    // sw, mode, pos, inc_time, inc_alarm, alarm_en
    add_vec(4'b0001, 2'd1, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd1, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0001, 2'd2, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd2, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0001, 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0100, 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0010, 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0001, 2'd1, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd1, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0010, 2'd1, 2'd1, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd1, 2'd1, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0010, 2'd1, 2'd2, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd1, 2'd2, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0100, 2'd1, 2'd2, 3'b100, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd1, 2'd2, 3'b000, 3'b000, 1'b0);
    add_vec(4'b1000, 2'd1, 2'd2, 3'b000, 3'b000, 1'b1);
    add_vec(4'b0000, 2'd1, 2'd2, 3'b000, 3'b000, 1'b1);
    add_vec(4'b1000, 2'd1, 2'd2, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd1, 2'd2, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0011, 2'd2, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0000, 2'd2, 2'd0, 3'b000, 3'b000, 1'b0);
    add_vec(4'b0100, 2'd2, 2'd0, 3'b000, 3'b001, 1'b0);
    add_vec(4'b0000, 2'd2, 2'd0, 3'b000, 3'b000, 1'b0);

    // Reset state
    rst = 1'b1;
    sw  = 4'b0000;
    step();
    step();
    check("rst_mode", 32'(o_mode), 32'd0);
    check("rst_pos", 32'(o_position), 32'd0);
    check("rst_inc_time", 32'(o_inc_time), 32'd0);
    check("rst_inc_alarm", 32'(o_inc_alarm), 32'd0);
    check("rst_alarm_en", 32'(o_alarm_en), 32'd0);
    check("rst_blank", 32'(o_blank), 32'd0);
    rst = 1'b0;
    step();

    // Vector table
    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      step();
      check($sformatf("vec%0d_mode", i), 32'(o_mode), 32'(vecs[i].mode));
      check($sformatf("vec%0d_pos", i), 32'(o_position), 32'(vecs[i].pos));
      check($sformatf("vec%0d_inc_time", i), 32'(o_inc_time), 32'(vecs[i].it));
      check($sformatf("vec%0d_inc_alarm", i), 32'(o_inc_alarm), 32'(vecs[i].ia));
      check($sformatf("vec%0d_alarm_en", i), 32'(o_alarm_en), 32'(vecs[i].en));
    end

    // Auto-repeat in ALARM_SET, position 0: pulses at offsets 0, 8, 11, 14, 17.
    sw = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      logic [2:0] exp_ia;
      step();
      exp_ia = (k == 0 || k == 8 || k == 11 || k == 14 || k == 17) ? 3'b001 : 3'b000;
      check($sformatf("rep%0d_inc_alarm", k), 32'(o_inc_alarm), 32'(exp_ia));
      check($sformatf("rep%0d_inc_time", k), 32'(o_inc_time), 32'd0);
      check($sformatf("rep%0d_blank", k), 32'(o_blank), 32'd0);
    end
    sw = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("rel%0d_inc_alarm", k), 32'(o_inc_alarm), 32'd0);
    end

    // Timeout: ALARM_SET -> CLOCK -> TIME_SET, then idle.
    sw = 4'b0001; step(); sw = 4'b0000; step();
    check("to_pre_mode", 32'(o_mode), 32'd0);
    sw = 4'b0001; step(); sw = 4'b0000;
    check("to_enter_mode", 32'(o_mode), 32'd1);
    for (int t = 1; t <= 50; t++) begin
      step();
      if (t == 49) check("to_49_mode", 32'(o_mode), 32'd1);
      if (t == 50) begin
        check("to_50_mode", 32'(o_mode), 32'd0);
        check("to_50_pos", 32'(o_position), 32'd0);
      end
    end
    // sw1 at cycle 40 pushes the return to cycle 90.
    sw = 4'b0001; step(); sw = 4'b0000;
    for (int t = 1; t <= 90; t++) begin
      if (t == 40) sw = 4'b0010;
      step();
      sw = 4'b0000;
      if (t == 40) check("to2_40_pos", 32'(o_position), 32'd1);
      if (t == 50) check("to2_50_mode", 32'(o_mode), 32'd1);
      if (t == 89) check("to2_89_mode", 32'(o_mode), 32'd1);
      if (t == 90) begin
        check("to2_90_mode", 32'(o_mode), 32'd0);
        check("to2_90_pos", 32'(o_position), 32'd0);
      end
    end

    // Blink in TIME_SET, position 1: 4 visible cycles then 4 blanked.
    sw = 4'b0001; step(); sw = 4'b0000;
    sw = 4'b0010; step(); sw = 4'b0000;
    check("blink_pos", 32'(o_position), 32'd1);
    for (int j = 0; j < 16; j++) begin
      logic [2:0] exp_bl;
      if (j > 0) step();
      exp_bl = (((j / 4) % 2) == 0) ? 3'b000 : 3'b010;
      check($sformatf("blink%0d", j), 32'(o_blank), 32'(exp_bl));
    end
    // Holding sw2 keeps the digit visible.
    sw = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("hold%0d_blank", k), 32'(o_blank), 32'd0);
      if (k == 0) check("hold_inc_time", 32'(o_inc_time), 32'b010);
    end

    // Reset on the edge a repeat pulse is due, with sw0 held through reset.
    rst = 1'b1;
    sw  = 4'b0101;
    step();
    check("midrst_inc_time", 32'(o_inc_time), 32'd0);
    check("midrst_mode", 32'(o_mode), 32'd0);
    check("midrst_pos", 32'(o_position), 32'd0);
    check("midrst_blank", 32'(o_blank), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("heldrst%0d_mode", k), 32'(o_mode), 32'd0);
      check($sformatf("heldrst%0d_inc", k), 32'({o_inc_time, o_inc_alarm}), 32'd0);
    end
    sw = 4'b0000; step();
    sw = 4'b0001; step(); sw = 4'b0000;
    check("after_rst_press_mode", 32'(o_mode), 32'd1);
    step();

    // Randomized run against the model.
    rst = 1'b1;
    sw  = 4'b0000;
    step();
    step();
    rst      = 1'b0;
    m_mode   = 0;
    m_pos    = 0;
    m_en     = 1'b0;
    m_held   = 1'b0;
    last_act = 0;
    press_t  = 0;
    blink_t  = 0;
    m_prev   = 4'b1111;
    for (int t = 0; t < 3000; t++) begin
      logic [3:0]  p;
      logic [2:0]  e_it, e_ia, e_bl;
      logic [13:0] exp_v, act_v;
      bit          quiet, rep, tmo, pulse, visible;
      int          d;

      quiet = ((t / 300) % 3) == 2;
      sw[0] = sw[0] ^ ($urandom_range(63) == 0);
      sw[1] = quiet ? 1'b0 : sw[1] ^ ($urandom_range(23) == 0);
      sw[2] = quiet ? 1'b0 : sw[2] ^ ($urandom_range(11) == 0);
      sw[3] = quiet ? 1'b0 : sw[3] ^ ($urandom_range(39) == 0);
      step();

      p      = sw & ~m_prev;
      m_prev = sw;
      d      = t - press_t;
      rep    = m_held && sw[2] &&
               (d == int'(REPEAT_DLY) ||
                (d > int'(REPEAT_DLY) && ((d - int'(REPEAT_DLY)) % int'(REPEAT_RATE)) == 0));
      tmo    = (m_mode != 0) && (t - last_act) == int'(TIMEOUT);
      pulse  = 1'b0;
      if (p[0]) begin
        m_mode   = (m_mode + 1) % 3;
        m_pos    = 0;
        m_held   = 1'b0;
        last_act = t;
        blink_t  = t;
      end else if (tmo) begin
        m_mode = 0;
        m_pos  = 0;
        m_held = 1'b0;
      end else if (p[1] && m_mode != 0) begin
        m_pos    = (m_pos + 1) % 3;
        last_act = t;
        blink_t  = t;
      end else if (p[2] && m_mode != 0) begin
        pulse    = 1'b1;
        m_held   = 1'b1;
        press_t  = t;
        last_act = t;
      end else if (rep) begin
        pulse    = 1'b1;
        last_act = t;
      end
      if (!sw[2] || m_mode == 0) m_held = 1'b0;
      if (p[3]) begin
        m_en     = !m_en;
        last_act = t;
      end

      e_it    = (pulse && m_mode == 1) ? 3'(1 << m_pos) : 3'b000;
      e_ia    = (pulse && m_mode == 2) ? 3'(1 << m_pos) : 3'b000;
      visible = (((t - blink_t) / int'(BLINK_DIV)) % 2) == 0;
      e_bl    = (m_mode != 0 && !visible && !m_held) ? 3'(1 << m_pos) : 3'b000;

      exp_v = {2'(m_mode), 2'(m_pos), e_it, e_ia, m_en, e_bl};
      act_v = {o_mode, o_position, o_inc_time, o_inc_alarm, o_alarm_en, o_blank};
      check($sformatf("rand%0d", t), 32'(act_v), 32'(exp_v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_sequencer.md
# set_sequencer

Sequencer for the clock project's setting path. It turns the four user buttons into a mode/position state machine. It produces single-cycle increment pulses for the time counters and the alarm registers, and a per-digit blank mask for the display blink. It sits between the debounced switch inputs and the sec/min/hour counter and alarm blocks. It replaces ad-hoc mode decoding and free-running blink generation in downstream blocks.

## Interface
- BLINK_DIV, 32'd25_000_000: clk cycles per blink half-period.
- TIMEOUT, 32'd500_000_000: idle cycles in a set mode before returning to clock mode.
- REPEAT_DLY, 32'd50_000_000: cycles sw2 is held before auto-repeat starts.
- REPEAT_RATE, 32'd10_000_000: cycles between auto-repeat pulses.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- i_sw0  in  1  mode button; debounced level, 1 = pressed.
- i_sw1  in  1  position button.
- i_sw2  in  1  increment button.
- i_sw3  in  1  alarm-enable toggle button.
- o_mode  out  2  0 = CLOCK, 1 = TIME_SET, 2 = ALARM_SET; 3 is never driven.
- o_position  out  2  0 = sec, 1 = min, 2 = hour; 3 is never driven.
- o_inc_time  out  3  one-hot increment pulse {hour,min,sec} to the time counters.
- o_inc_alarm  out  3  one-hot increment pulse {hour,min,sec} to the alarm registers.
- o_alarm_en  out  1  alarm enable.
- o_blank  out  3  one-hot {hour,min,sec} digit-pair blank mask for the display.

## Operation
- Edge detect: prev_swN registers hold the last sampled level; press = i_swN & ~prev_swN. Reset loads prev_swN = 1, so a button held through reset does not fire until it is released and pressed again.
- Same-cycle priority: sw0 > sw1 > sw2; only the highest-priority press in a cycle acts. sw3 is handled independently of the other three.
- sw0 press: o_mode advances 0→1→2→0. o_position ← 0. Any active repeat is cancelled. The timeout counter and blink are restarted.
- sw1 press, mode ≠ 0: o_position advances 0→1→2→0. Timeout and blink are restarted. In mode 0 the press is ignored.
- sw2 press, mode ≠ 0: pulse bit o_position on o_inc_time (mode 1) or o_inc_alarm (mode 2). The hold counter starts.
- sw2 in mode 0: ignored.
- Auto-repeat: while sw2 stays high in a set mode, further pulses occur at REPEAT_DLY cycles after the press, then every REPEAT_RATE cycles after that. Releasing sw2 clears the hold counter. Each pulse restarts the timeout.
- sw3 press, any mode: o_alarm_en toggles.
- Timeout: in mode ≠ 0 the idle counter increments each cycle. Any acted-upon press or pulse clears it. On reaching TIMEOUT-1: o_mode ← 0, o_position ← 0, repeat cancelled. Timeout has priority over a same-cycle sw1/sw2 press; an sw0 press in that cycle is applied instead of the timeout.
- Blink: the phase counter counts 0..BLINK_DIV-1 and toggles the phase bit at wrap. Restart sets counter 0 and phase 1 (visible).
- o_blank = one-hot(o_position) when mode ≠ 0, phase == 0 and sw2 is not held; otherwise 0. While incrementing, the edited digit stays visible.
- All counters are 32 bits and compare with ==, so there is no overflow. In mode 0 the idle, hold and blink counters are held at 0.

## Timing
- All outputs are registered.
- A press sampled at edge k updates the mode, position and alarm_en registers at edge k; the new values are visible in cycle k+1.
- Each o_inc_* pulse is exactly one cycle high, at most one bit set, and o_inc_time/o_inc_alarm are never high together.
- Reset values: o_mode 0, o_position 0, o_inc_time 0, o_inc_alarm 0, o_alarm_en 0, o_blank 0. All counters are 0 and phase is 1.
- Reset asserted mid-repeat or mid-set overrides everything on the same edge; no pulse is emitted on that edge.

## Test plan
- Parameters for all scenarios: BLINK_DIV=4, TIMEOUT=50, REPEAT_DLY=8, REPEAT_RATE=3.
- Three sw0 presses → o_mode sequence 1, 2, 0. o_position reads 0 after each press.
- Mode 1, two sw1 presses, then one sw2 press → o_position 2 and a single-cycle o_inc_time = 3'b100. o_inc_alarm stays 0.
- Mode 2, position 0, sw2 held 20 cycles → o_inc_alarm = 3'b001 at offsets 0, 8, 11, 14, 17. No pulses after release.
- Mode 1, idle 50 cycles → o_mode 0 and o_position 0 at cycle 50. Pressing sw1 at cycle 40 instead moves the return to cycle 90.
- Mode 1, position 1, idle → o_blank alternates 3'b000 ×4 cycles and 3'b010 ×4 cycles. Holding sw2 forces o_blank 0.
- sw0 and sw1 pressed in the same cycle → only the mode advances. sw3 pressed twice → o_alarm_en 1 then 0. sw0 held through reset → no mode change after reset deasserts.
